// File: rtl/stall_ctrl_pkg.sv
// Shared FSM state encoding and default opcode/mask constants for the MIPS stall controller.
// Pure definitions: no latency, no flow control.
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int          DEF_OP_W     = 6;
  localparam logic [5:0]  HLT_OP_DEF   = 6'b010001;
  localparam logic [5:0]  HLT_MASK_DEF = 6'b111111;
  localparam logic [5:0]  LD_OP_DEF    = 6'b010100;
  localparam logic [5:0]  LD_MASK_DEF  = 6'b111111;
  localparam logic [5:0]  JMP_OP_DEF   = 6'b011100;
  localparam logic [5:0]  JMP_MASK_DEF = 6'b111100;

endpackage

// File: rtl/stall_timer.sv
// Loadable down-counter that holds at zero; counts only while en=1.
// zero is combinational from the register; load takes effect on the next edge.
module stall_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stall_ctrl_unit.sv
// Decode-stage stall controller: combinational stall/flush from opcode match, stall_pm one cycle later.
// Stall may be extended by ext_stall; halts are sticky until resume.
module stall_ctrl_unit
  import stall_ctrl_pkg::*;
#(
  parameter int              OP_W      = DEF_OP_W,
  parameter logic [OP_W-1:0] HLT_OP    = HLT_OP_DEF,
  parameter logic [OP_W-1:0] HLT_MASK  = HLT_MASK_DEF,
  parameter logic [OP_W-1:0] LD_OP     = LD_OP_DEF,
  parameter logic [OP_W-1:0] LD_MASK   = LD_MASK_DEF,
  parameter logic [OP_W-1:0] JMP_OP    = JMP_OP_DEF,
  parameter logic [OP_W-1:0] JMP_MASK  = JMP_MASK_DEF,
  parameter int              LD_STALL  = 1,
  parameter int              JMP_STALL = 2,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op_dec,
  input  logic             ext_stall,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAX_STALL = (LD_STALL > JMP_STALL) ? LD_STALL : JMP_STALL;
  localparam int TW        = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
  // The detection cycle is itself the first stall cycle, and WAIT exits on timer==0.
  localparam logic [TW-1:0] LD_LOAD  = TW'((LD_STALL  > 1) ? LD_STALL  - 2 : 0);
  localparam logic [TW-1:0] JMP_LOAD = TW'((JMP_STALL > 1) ? JMP_STALL - 2 : 0);

  state_t        state, state_nxt;
  logic          sup, sup_nxt;
  logic          fsm_stall, fsm_flush;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          hlt_hit, ld_hit, jmp_hit;

  assign hlt_hit = ((op_dec & HLT_MASK) == (HLT_OP & HLT_MASK)) && !sup;
  assign jmp_hit = ((op_dec & JMP_MASK) == (JMP_OP & JMP_MASK)) && !sup;
  assign ld_hit  = ((op_dec & LD_MASK)  == (LD_OP  & LD_MASK))  && !sup;

  stall_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (!ext_stall),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    sup_nxt   = sup;
    fsm_stall = 1'b0;
    fsm_flush = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      RUN: begin
        if (hlt_hit) begin
          fsm_stall = 1'b1;
          sup_nxt   = 1'b0;
          state_nxt = HALT;
        end else if (jmp_hit) begin
          fsm_stall = 1'b1;
          fsm_flush = 1'b1;
          if (JMP_STALL > 1) begin
            tmr_load  = 1'b1;
            tmr_val   = JMP_LOAD;
            sup_nxt   = 1'b0;
            state_nxt = WAIT;
          end else begin
            sup_nxt = 1'b1;
          end
        end else if (ld_hit) begin
          fsm_stall = 1'b1;
          if (LD_STALL > 1) begin
            tmr_load  = 1'b1;
            tmr_val   = LD_LOAD;
            sup_nxt   = 1'b0;
            state_nxt = WAIT;
          end else begin
            sup_nxt = 1'b1;
          end
        end else if (!ext_stall) begin
          // Held opcode stays masked for as long as the pipeline is frozen externally.
          sup_nxt = 1'b0;
        end
      end
      WAIT: begin
        fsm_stall = 1'b1;
        if (tmr_zero && !ext_stall) begin
          sup_nxt   = 1'b1;
          state_nxt = RUN;
        end
      end
      HALT: begin
        fsm_stall = 1'b1;
        if (resume) begin
          sup_nxt   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        sup_nxt   = 1'b0;
        state_nxt = RUN;
      end
    endcase
  end

  assign stall = reset && (fsm_stall || ext_stall);
  assign flush = reset && fsm_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      sup       <= 1'b0;
      stall_pm  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sup      <= sup_nxt;
      stall_pm <= stall;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stall_ctrl_unit.sv
// Directed bench for stall_ctrl_unit with a 4-bit stall counter so saturation is reachable.
module tb_stall_ctrl_unit;

  logic       clk;
  logic       reset;
  logic [5:0] op_dec;
  logic       ext_stall;
  logic       resume;
  logic       stall;
  logic       stall_pm;
  logic       flush;
  logic [3:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_JMP = 6'b011111;
  localparam logic [5:0] OP_JM2 = 6'b011101;
  localparam logic [5:0] OP_HLT = 6'b010001;

  stall_ctrl_unit #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_dec    (op_dec),
    .ext_stall (ext_stall),
    .resume    (resume),
    .stall     (stall),
    .stall_pm  (stall_pm),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, check comb outputs mid-cycle, then stall_pm after the edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic ext, input logic res,
                     input logic es, input logic ef);
    op_dec    = op;
    ext_stall = ext;
    resume    = res;
    @(negedge clk);
    chk({tag, "_stall"}, {15'd0, stall}, {15'd0, es});
    chk({tag, "_flush"}, {15'd0, flush}, {15'd0, ef});
    @(posedge clk);
    #1;
    chk({tag, "_pm"}, {15'd0, stall_pm}, {15'd0, es});
  endtask

  task automatic do_reset();
    op_dec    = OP_NOP;
    ext_stall = 1'b0;
    resume    = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    op_dec    = OP_NOP;
    ext_stall = 1'b0;
    resume    = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_flush", {15'd0, flush}, 16'd0);
    chk("rst_pm",    {15'd0, stall_pm}, 16'd0);
    chk("rst_cnt",   {12'd0, stall_cnt}, 16'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Load: single stall cycle, held opcode not re-served.
    cyc("ld0", OP_LD, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("ld1", OP_LD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_cnt", {12'd0, stall_cnt}, 16'd1);
    cyc("ld2", OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0);

    // Jump: two stall cycles, one flush.
    do_reset();
    cyc("j0", OP_JMP, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("j1", OP_JMP, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("j2", OP_JMP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("j_cnt", {12'd0, stall_cnt}, 16'd2);

    // Halt released by resume in cycle 4.
    do_reset();
    cyc("h0", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("h1", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("h2", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("h3", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("h4", OP_HLT, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("h5", OP_HLT, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("h6", OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("h_cnt", {12'd0, stall_cnt}, 16'd5);

    // Jump extended by ext_stall in cycle 1; flush stays a single pulse.
    do_reset();
    cyc("x0", OP_JM2, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("x1", OP_JM2, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("x2", OP_JM2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("x3", OP_JM2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("x4", OP_NOP, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("x5", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x_cnt", {12'd0, stall_cnt}, 16'd4);

    // Reset asserted mid-halt clears everything immediately.
    do_reset();
    cyc("r0", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("r1", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("r_stall", {15'd0, stall}, 16'd0);
    chk("r_pm",    {15'd0, stall_pm}, 16'd0);
    chk("r_cnt",   {12'd0, stall_cnt}, 16'd0);
    op_dec = OP_NOP;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("r2", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("r3", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);

    // Counter saturation with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc("sat", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("sat_cnt0", {12'd0, stall_cnt}, 16'd15);
    cyc("sat_a", OP_HLT, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("sat_b", OP_HLT, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("sat_c", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt1", {12'd0, stall_cnt}, 16'd15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
